// File: rtl/move_gen_sched.sv
// move_gen_sched: scans a 64-byte board in SDRAM and dispatches each
// own piece to its move generator, packing child boards at dst.
// Ports: slave_* HPS regs (0 start/status, 1 src, 2 dst, 3 side,
//   4 total, 5 cycles), master_* SDRAM board reads, gen_* generator.
// Option: SCHED_CYCLE_COUNT_EN adds a busy-cycle counter at reg 5.
module move_gen_sched #(
  parameter int ADDR_W     = 32,
  parameter int MAX_BOARDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              slave_waitrequest,
  input  logic [3:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic              master_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic [31:0]       master_readdata,
  input  logic              master_readdatavalid,
  output logic [2:0]        gen_sel,
  input  logic              gen_waitrequest,
  output logic [3:0]        gen_address,
  output logic              gen_read,
  input  logic [31:0]       gen_readdata,
  output logic              gen_write,
  output logic [31:0]       gen_writedata
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RD_REQ  = 4'd1;
  localparam logic [3:0] S_RD_WAIT = 4'd2;
  localparam logic [3:0] S_DECODE  = 4'd3;
  localparam logic [3:0] S_G_SRC   = 4'd4;
  localparam logic [3:0] S_G_DST   = 4'd5;
  localparam logic [3:0] S_G_X     = 4'd6;
  localparam logic [3:0] S_G_Y     = 4'd7;
  localparam logic [3:0] S_G_RUN   = 4'd8;
  localparam logic [3:0] S_ACCUM   = 4'd9;
  localparam logic [3:0] S_NEXT    = 4'd10;

  logic [3:0]        state_q, state_d;
  logic              ack_q;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] src_q, dst_q, dst_cur_q;
  logic              side_q;
  logic [5:0]        i_q;
  logic [7:0]        sq_q;
  logic [31:0]       n_q, total_q;
  logic              ovf_q;
  logic [2:0]        sel_q;
  logic [31:0]       cyc_rd;

  logic idle, rd_blk, acc, start, cfg_wr;
  logic [7:0]  mag;
  logic [2:0]  typ;
  logic        own;
  logic [32:0] sum;
  logic        fits;
  logic        unused_ok;

  assign unused_ok = ^master_readdata[31:8];
  assign idle   = state_q == S_IDLE;
  // Status read blocks until the run is over.
  assign rd_blk = slave_read && slave_address == 4'd0 && !idle;
  // ack_q gives the one-cycle waitrequest low per access.
  assign acc    = (slave_read || slave_write) && !ack_q && !rd_blk;
  assign start  = acc && slave_write && slave_address == 4'd0 && idle;
  assign cfg_wr = acc && slave_write && idle;

  always_comb begin
    mag = sq_q[7] ? (~sq_q + 8'd1) : sq_q;
    typ = 3'd0;
    unique case (1'b1)
      (mag >= 8'd1  && mag <= 8'd8):  typ = 3'd1;
      (mag >= 8'd9  && mag <= 8'd18): typ = 3'd2;
      (mag >= 8'd19 && mag <= 8'd28): typ = 3'd3;
      (mag >= 8'd29 && mag <= 8'd38): typ = 3'd4;
      (mag >= 8'd39 && mag <= 8'd47): typ = 3'd5;
      (mag == 8'd48):                 typ = 3'd6;
      default:                        typ = 3'd0;
    endcase
  end

  assign own  = (sq_q != 8'd0) && (sq_q[7] == side_q) && (typ != 3'd0);
  assign sum  = {1'b0, total_q} + {1'b0, n_q};
  assign fits = sum <= 33'(MAX_BOARDS);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_RD_REQ;
      S_RD_REQ:  if (!master_waitrequest) state_d = S_RD_WAIT;
      S_RD_WAIT: if (master_readdatavalid) state_d = S_DECODE;
      S_DECODE:  state_d = own ? S_G_SRC : S_NEXT;
      S_G_SRC:   if (!gen_waitrequest) state_d = S_G_DST;
      S_G_DST:   if (!gen_waitrequest) state_d = S_G_X;
      S_G_X:     if (!gen_waitrequest) state_d = S_G_Y;
      S_G_Y:     if (!gen_waitrequest) state_d = S_G_RUN;
      S_G_RUN:   if (!gen_waitrequest) state_d = S_ACCUM;
      S_ACCUM:   state_d = fits ? S_NEXT : S_IDLE;
      S_NEXT:    state_d = (i_q == 6'd63) ? S_IDLE : S_RD_REQ;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = 32'd0;
    case (slave_address)
      4'd0:    rdata_d = {ovf_q, total_q[30:0]};
      4'd1:    rdata_d = 32'(src_q);
      4'd2:    rdata_d = 32'(dst_q);
      4'd3:    rdata_d = {31'd0, side_q};
      4'd4:    rdata_d = total_q;
      4'd5:    rdata_d = cyc_rd;
      default: rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ack_q     <= 1'b0;
      rdata_q   <= 32'd0;
      src_q     <= '0;
      dst_q     <= '0;
      dst_cur_q <= '0;
      side_q    <= 1'b0;
      i_q       <= 6'd0;
      sq_q      <= 8'd0;
      n_q       <= 32'd0;
      total_q   <= 32'd0;
      ovf_q     <= 1'b0;
      sel_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      ack_q   <= acc;
      if (acc && slave_read) rdata_q <= rdata_d;
      if (cfg_wr) begin
        case (slave_address)
          4'd1:    src_q  <= slave_writedata[ADDR_W-1:0];
          4'd2:    dst_q  <= slave_writedata[ADDR_W-1:0];
          4'd3:    side_q <= slave_writedata[0];
          default: ;
        endcase
      end
      if (start) begin
        total_q   <= 32'd0;
        ovf_q     <= 1'b0;
        i_q       <= 6'd0;
        dst_cur_q <= dst_q;
      end
      if (state_q == S_RD_WAIT && master_readdatavalid)
        sq_q <= master_readdata[7:0];
      if (state_q == S_DECODE && own) sel_q <= typ;
      if (state_q == S_G_RUN && !gen_waitrequest) n_q <= gen_readdata;
      if (state_q == S_ACCUM) begin
        if (fits) begin
          total_q   <= sum[31:0];
          dst_cur_q <= dst_cur_q + ADDR_W'({n_q, 6'd0});
        end else begin
          ovf_q   <= 1'b1;
          total_q <= 32'(MAX_BOARDS);
          sel_q   <= 3'd0;
        end
      end
      if (state_q == S_NEXT) begin
        sel_q <= 3'd0;
        i_q   <= i_q + 6'd1;
      end
    end
  end

`ifdef SCHED_CYCLE_COUNT_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cyc_q <= 32'd0;
    else if (start) cyc_q <= 32'd0;
    else if (!idle && cyc_q != 32'hFFFF_FFFF) cyc_q <= cyc_q + 32'd1;
  end
  assign cyc_rd = cyc_q;
`else
  assign cyc_rd = 32'd0;
`endif

  assign slave_waitrequest = !ack_q;
  assign slave_readdata    = rdata_q;

  // Strobes are gated by rst_n so a reset pulse kills them at once.
  assign master_read    = rst_n && state_q == S_RD_REQ;
  assign master_address = (state_q == S_RD_REQ) ?
                          src_q + ADDR_W'(i_q) : '0;
  assign gen_sel        = sel_q;
  assign gen_read       = rst_n && state_q == S_G_RUN;
  assign gen_write      = rst_n && (state_q == S_G_SRC ||
                                    state_q == S_G_DST ||
                                    state_q == S_G_X   ||
                                    state_q == S_G_Y);

  always_comb begin
    gen_address   = 4'd0;
    gen_writedata = 32'd0;
    case (state_q)
      S_G_SRC: begin
        gen_address   = 4'd1;
        gen_writedata = 32'(src_q);
      end
      S_G_DST: begin
        gen_address   = 4'd2;
        gen_writedata = 32'(dst_cur_q);
      end
      S_G_X: begin
        gen_address   = 4'd3;
        gen_writedata = {29'd0, i_q[2:0]};
      end
      S_G_Y: begin
        gen_address   = 4'd4;
        gen_writedata = {29'd0, i_q[5:3]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_move_gen_sched.sv
// tb_move_gen_sched: directed bench with mock SDRAM and generator.
// DUT a uses default MAX_BOARDS, DUT b uses MAX_BOARDS=10.
module tb_move_gen_sched;

  localparam logic [31:0] SRC = 32'h0000_1000;
  localparam logic [31:0] DST = 32'h0002_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  s_addr;
  logic        s_rd, s_wr;
  logic [31:0] s_wdata;
  logic        use_b;
  logic        stall;

  logic        m_wait = 1'b0;
  logic        m_rdv  = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic        g_wait = 1'b0;
  logic [31:0] g_rdata;
  logic [31:0] gx = 32'd0;

  logic        swait_a, swait_b, mrd_a, mrd_b, grd_a, grd_b, gwr_a, gwr_b;
  logic [31:0] srd_a, srd_b, maddr_a, maddr_b, gwd_a, gwd_b;
  logic [2:0]  gsel_a, gsel_b;
  logic [3:0]  gaddr_a, gaddr_b;

  logic        swait, mrd, grd, gwr;
  logic [31:0] srdata, maddr, gwdata;
  logic [2:0]  gsel;
  logic [3:0]  gaddr;

  assign swait  = use_b ? swait_b : swait_a;
  assign srdata = use_b ? srd_b   : srd_a;
  assign mrd    = use_b ? mrd_b   : mrd_a;
  assign maddr  = use_b ? maddr_b : maddr_a;
  assign grd    = use_b ? grd_b   : grd_a;
  assign gwr    = use_b ? gwr_b   : gwr_a;
  assign gwdata = use_b ? gwd_b   : gwd_a;
  assign gsel   = use_b ? gsel_b  : gsel_a;
  assign gaddr  = use_b ? gaddr_b : gaddr_a;
  assign g_rdata = gx + 32'd1;

  move_gen_sched u_a (
    .clk(clk), .rst_n(rst_n),
    .slave_waitrequest(swait_a), .slave_address(s_addr),
    .slave_read(s_rd && !use_b), .slave_readdata(srd_a),
    .slave_write(s_wr && !use_b), .slave_writedata(s_wdata),
    .master_waitrequest(m_wait), .master_address(maddr_a),
    .master_read(mrd_a), .master_readdata(m_rdata),
    .master_readdatavalid(m_rdv),
    .gen_sel(gsel_a), .gen_waitrequest(g_wait),
    .gen_address(gaddr_a), .gen_read(grd_a),
    .gen_readdata(g_rdata), .gen_write(gwr_a),
    .gen_writedata(gwd_a)
  );

  move_gen_sched #(.MAX_BOARDS(10)) u_b (
    .clk(clk), .rst_n(rst_n),
    .slave_waitrequest(swait_b), .slave_address(s_addr),
    .slave_read(s_rd && use_b), .slave_readdata(srd_b),
    .slave_write(s_wr && use_b), .slave_writedata(s_wdata),
    .master_waitrequest(m_wait), .master_address(maddr_b),
    .master_read(mrd_b), .master_readdata(m_rdata),
    .master_readdatavalid(m_rdv),
    .gen_sel(gsel_b), .gen_waitrequest(g_wait),
    .gen_address(gaddr_b), .gen_read(grd_b),
    .gen_readdata(g_rdata), .gen_write(gwr_b),
    .gen_writedata(gwd_b)
  );

  logic [7:0]  board [64];
  int          rd_cnt = 0;
  int          bad_addr = 0;
  int          g_n = 0;
  int          g_rdn = 0;
  logic [3:0]  lg_a [512];
  logic [31:0] lg_d [512];
  logic [2:0]  lg_s [512];

  // Mock SDRAM: one-cycle readdatavalid after an accepted read.
  always @(posedge clk) begin
    m_rdv <= 1'b0;
    if (mrd && !m_wait) begin
      m_rdv   <= 1'b1;
      m_rdata <= {24'h0, board[maddr[5:0]]};
      rd_cnt  <= rd_cnt + 1;
      if (maddr[31:6] != SRC[31:6]) bad_addr <= bad_addr + 1;
    end
    m_wait <= stall ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Mock generator: logs writes, read 0 returns x+1.
  always @(posedge clk) begin
    if (gwr && !g_wait) begin
      lg_a[g_n % 512] <= gaddr;
      lg_d[g_n % 512] <= gwdata;
      lg_s[g_n % 512] <= gsel;
      g_n <= g_n + 1;
      if (gaddr == 4'd3) gx <= gwdata;
    end
    if (grd && !g_wait) g_rdn <= g_rdn + 1;
    g_wait <= stall ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Stall monitor: a stalled strobe must hold with stable address/data.
  int          viol = 0;
  logic        p_rst = 1'b0, p_mrd = 1'b0, p_mw = 1'b0;
  logic        p_gwr = 1'b0, p_grd = 1'b0, p_gw = 1'b0;
  logic [31:0] p_maddr = 32'd0, p_gwd = 32'd0;
  logic [3:0]  p_ga = 4'd0;
  always @(posedge clk) begin
    if (rst_n && p_rst) begin
      if (p_mrd && p_mw && (!mrd || maddr != p_maddr)) viol <= viol + 1;
      if (p_gwr && p_gw && (!gwr || gaddr != p_ga || gwdata != p_gwd))
        viol <= viol + 1;
      if (p_grd && p_gw && (!grd || gaddr != p_ga)) viol <= viol + 1;
    end
    p_rst <= rst_n; p_mrd <= mrd; p_mw <= m_wait; p_maddr <= maddr;
    p_gwr <= gwr; p_grd <= grd; p_gw <= g_wait; p_ga <= gaddr;
    p_gwd <= gwdata;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input bit wr, input logic [3:0] a,
                      input logic [31:0] d, output logic [31:0] q);
    int k;
    @(negedge clk);
    s_addr = a; s_wdata = d; s_wr = wr; s_rd = !wr;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (swait && k < 20000);
    if (swait) chk("bus_timeout", {31'd0, swait}, 32'd0);
    q = srdata;
    @(posedge clk);
    #1;
    s_rd = 1'b0; s_wr = 1'b0;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    xfer(1'b1, a, d, q);
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] q);
    xfer(1'b0, a, 32'd0, q);
  endtask

  task automatic start_run(input logic [31:0] dst, input logic side);
    bus_wr(4'd1, SRC);
    bus_wr(4'd2, dst);
    bus_wr(4'd3, {31'd0, side});
    bus_wr(4'd0, 32'd1);
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 8'd0;
  endtask

  // White uses range low ends, black the high ends.
  task automatic set_initial();
    logic [7:0] wr8 [8];
    logic [7:0] bk8 [8];
    wr8 = '{8'd9, 8'd19, 8'd29, 8'd39, 8'd48, 8'd29, 8'd19, 8'd9};
    bk8 = '{8'd18, 8'd28, 8'd38, 8'd47, 8'd48, 8'd38, 8'd28, 8'd18};
    clear_board();
    for (int i = 0; i < 8; i++) begin
      board[i]      = wr8[i];
      board[8 + i]  = 8'd1;
      board[48 + i] = 8'(-8);
      board[56 + i] = 8'(-bk8[i]);
    end
  endtask

  int exp_sel [16] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 3, 4, 5, 6, 4, 3, 2};

  initial begin
    logic [31:0] r;
    logic [31:0] dexp;
    int g0, rn0, rc0, b;
    s_rd = 1'b0; s_wr = 1'b0; s_addr = 4'd0; s_wdata = 32'd0;
    use_b = 1'b0; stall = 1'b0; rst_n = 1'b0;
    clear_board();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_swait", {31'd0, swait_a}, 32'd1);
    chk("rst_strobes", {28'd0, mrd_a, grd_a, gwr_a, swait_b}, 32'd1);
    chk("rst_maddr", maddr_a, 32'd0);
    chk("rst_gen", {gwd_a[27:0], gaddr_a}, 32'd0);
    chk("rst_gsel", {29'd0, gsel_a}, 32'd0);
    chk("rst_rdata", srd_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_rd(4'd0, r);
    chk("idle_status", r, 32'd0);
    bus_rd(4'd7, r);
    chk("unused_addr", r, 32'd0);

    // Single white queen on square 30: x=6, y=3.
    board[30] = 8'd39;
    g0 = g_n; rn0 = g_rdn;
    start_run(DST, 1'b0);
    bus_rd(4'd0, r);
    chk("q_status", r, 32'd7);
    chk("q_nwr", g_n - g0, 32'd4);
    chk("q_nrd", g_rdn - rn0, 32'd1);
    chk("q_w0", {lg_a[g0 % 512], lg_d[g0 % 512][27:0]}, {4'd1, SRC[27:0]});
    chk("q_w1", lg_d[(g0 + 1) % 512], DST);
    chk("q_w2", {lg_a[(g0 + 2) % 512], lg_d[(g0 + 2) % 512][27:0]},
        {4'd3, 28'd6});
    chk("q_w3", {lg_a[(g0 + 3) % 512], lg_d[(g0 + 3) % 512][27:0]},
        {4'd4, 28'd3});
    chk("q_a1", {28'd0, lg_a[(g0 + 1) % 512]}, 32'd2);
    chk("q_sel", {29'd0, lg_s[g0 % 512]}, 32'd5);

    // Initial position, black: 16 dispatches, total 72.
    set_initial();
    g0 = g_n; rn0 = g_rdn;
    start_run(DST, 1'b1);
    bus_wr(4'd2, 32'hDEAD_0000);
    bus_wr(4'd0, 32'd1);
    bus_rd(4'd0, r);
    chk("init_status", r, 32'd72);
    bus_rd(4'd4, r);
    chk("init_total", r, 32'd72);
    chk("init_ndisp", g_n - g0, 32'd64);
    chk("init_nrd", g_rdn - rn0, 32'd16);
    dexp = DST;
    for (int j = 0; j < 16; j++) begin
      b = g0 + 4 * j;
      chk($sformatf("init_sel%0d", j), {29'd0, lg_s[b % 512]},
          32'(exp_sel[j]));
      chk($sformatf("init_dst%0d", j), lg_d[(b + 1) % 512], dexp);
      chk($sformatf("init_y%0d", j), lg_d[(b + 3) % 512],
          32'(6 + j / 8));
      dexp = dexp + 32'(64 * (j % 8 + 1));
    end

    // No own pieces: zeros, out-of-range values, a white queen.
    clear_board();
    board[5] = 8'd49; board[17] = 8'd127; board[40] = 8'h80;
    board[63] = 8'hCF; board[20] = 8'd39;
    g0 = g_n; rn0 = g_rdn; rc0 = rd_cnt;
    start_run(DST, 1'b1);
    bus_rd(4'd0, r);
    chk("empty_status", r, 32'd0);
    chk("empty_reads", rd_cnt - rc0, 32'd64);
    chk("empty_gen", (g_n - g0) + (g_rdn - rn0), 32'd0);
    bus_rd(4'd5, r);
`ifdef SCHED_CYCLE_COUNT_EN
    chk("cyc_count", r, 32'd256);
`else
    chk("cyc_absent", r, 32'd0);
`endif

    // Overflow with MAX_BOARDS=10: 1+2+3+4 fits, the fifth does not.
    use_b = 1'b1;
    set_initial();
    g0 = g_n; rn0 = g_rdn;
    start_run(DST, 1'b0);
    bus_rd(4'd0, r);
    chk("ovf_status", r, 32'h8000_000A);
    bus_rd(4'd4, r);
    chk("ovf_total", r, 32'd10);
    chk("ovf_nrd", g_rdn - rn0, 32'd5);
    chk("ovf_gsel", {29'd0, gsel_b}, 32'd0);
    use_b = 1'b0;

    // Random stalls and a reset pulse in the middle of a run.
    stall = 1'b1;
    set_initial();
    start_run(DST, 1'b1);
    repeat (150) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_strobes", {29'd0, mrd_a, grd_a, gwr_a}, 32'd0);
    chk("mid_rst_swait", {31'd0, swait_a}, 32'd1);
    chk("mid_rst_gsel", {29'd0, gsel_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", {29'd0, mrd_a, grd_a, gwr_a}, 32'd0);
    bus_rd(4'd0, r);
    chk("post_rst_status", r, 32'd0);
    clear_board();
    board[30] = 8'd39;
    g0 = g_n;
    start_run(DST, 1'b0);
    bus_rd(4'd0, r);
    chk("rerun_status", r, 32'd7);
    chk("rerun_sel", {29'd0, lg_s[g0 % 512]}, 32'd5);
    chk("rerun_dst", lg_d[(g0 + 1) % 512], DST);
    stall = 1'b0;
    repeat (4) @(negedge clk);
    chk("stall_stable", viol, 32'd0);
    chk("sdram_addr", bad_addr, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
